scpu_pipe: RTL and testbench

SCPU_PIPE -- requirements
Module: scpu_pipe

---
 rtl/scpu_pipe.sv | 165 ++++++++++++++++
 tb/tb_scpu_pipe.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scpu_pipe.sv
// scpu_pipe: tiny two-stage (IF/EX) 8-bit-instruction CPU with a 4-entry
// register file, a write-only-from-outside instruction memory and an
// IDLE/RUN/HALT control FSM.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start           one-cycle request to begin execution at PC 0
//   imem_we/addr/wdata  instruction-memory write port (ignored while running)
//   dbg_sel/dbg_val combinational read of one register for debug
//   pc              current fetch PC
//   running/halted  FSM state flags (registered)
//   retired         instructions executed since the last start
module scpu_pipe #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              imem_we,
  input  logic [PC_W-1:0]   imem_addr,
  input  logic [7:0]        imem_wdata,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_val,
  output logic [PC_W-1:0]   pc,
  output logic              running,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int DEPTH = 2 ** PC_W;

  state_t            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   pc_d;
  logic              ifValid_q;
  logic [7:0]        ifInstr_q;
  logic [PC_W-1:0]   ifPc_q;
  logic [CNT_W-1:0]  retired_q;
  logic [CNT_W-1:0]  retired_d;
  logic              running_q;
  logic              halted_q;
  logic [DATA_W-1:0] regs_q [4];
  logic [7:0]        imem [DEPTH];

  logic [1:0]        exOp;
  logic [1:0]        exRd;
  logic [1:0]        exRs1;
  logic [1:0]        exRs2;
  logic [PC_W-1:0]   exTgt;
  logic              exTaken;
  logic              exHalt;
  logic              wbEn;
  logic [DATA_W-1:0] wbData;

  // Field decode of the instruction sitting in EX.
  assign exOp  = ifInstr_q[7:6];
  assign exRd  = ifInstr_q[5:4];
  assign exRs1 = ifInstr_q[3:2];
  assign exRs2 = ifInstr_q[1:0];
  assign exTgt = PC_W'(ifInstr_q[5:2]);

  // A branch compares against r0, not against zero; a taken branch back to
  // its own address is the program's way of saying "done".
  assign exTaken = ifValid_q && (exOp == 2'b11) && (regs_q[exRs2] != regs_q[0]);
  assign exHalt  = exTaken && (exTgt == ifPc_q);

  assign pc_d      = pc_q + PC_W'(1);
  assign retired_d = retired_q + CNT_W'(1);

  // Write-back value; registers are read in the same cycle they were written
  // by the previous instruction, so no forwarding path is needed.
  always_comb begin
    wbEn   = 1'b0;
    wbData = '0;
    if (ifValid_q) begin
      unique case (exOp)
        2'b00: begin wbEn = 1'b1; wbData = regs_q[exRs1] + regs_q[exRs2]; end
        2'b01: begin wbEn = 1'b1; wbData = regs_q[exRs2]; end
        2'b10: begin wbEn = 1'b1; wbData = DATA_W'(ifInstr_q[3:0]); end
        default: begin wbEn = 1'b0; wbData = '0; end
      endcase
    end
  end

  // Instruction memory has no reset; reset only blocks a coincident write.
  always_ff @(posedge clk) begin
    if (!rst && imem_we && (state_q != RUN)) begin
      imem[imem_addr] <= imem_wdata;
    end
  end

  // Control FSM plus the whole pipeline state. In RUN each cycle executes the
  // IF/EX instruction (if valid) and either fetches the next word or, on a
  // taken branch, redirects the PC and inserts a one-cycle bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      ifValid_q <= 1'b0;
      ifInstr_q <= '0;
      ifPc_q    <= '0;
      retired_q <= '0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE, HALT: begin
          if (start) begin
            state_q   <= RUN;
            pc_q      <= '0;
            ifValid_q <= 1'b0;
            retired_q <= '0;
            running_q <= 1'b1;
            halted_q  <= 1'b0;
          end
        end
        RUN: begin
          if (ifValid_q) begin
            retired_q <= retired_d;
            if (wbEn) begin
              regs_q[exRd] <= wbData;
            end
          end
          if (exTaken) begin
            pc_q      <= exTgt;
            ifValid_q <= 1'b0;
            if (exHalt) begin
              state_q   <= HALT;
              running_q <= 1'b0;
              halted_q  <= 1'b1;
            end
          end else begin
            ifInstr_q <= imem[pc_q];
            ifPc_q    <= pc_q;
            ifValid_q <= 1'b1;
            pc_q      <= pc_d;
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
          halted_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_val = regs_q[dbg_sel];
  assign pc      = pc_q;
  assign running = running_q;
  assign halted  = halted_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_scpu_pipe.sv
// tb_scpu_pipe: directed and randomized programs for scpu_pipe, checked
// against an instruction-level interpreter of the ISA (final registers, PC,
// retired count and number of RUN cycles until halt).
module tb_scpu_pipe;

  localparam int DATA_W = 8;
  localparam int PC_W   = 4;
  localparam int CNT_W  = 16;
  localparam int DEPTH  = 16;
  localparam int BOUND  = 2000;

  logic              clk;
  logic              rst;
  logic              start;
  logic              imem_we;
  logic [PC_W-1:0]   imem_addr;
  logic [7:0]        imem_wdata;
  logic [1:0]        dbg_sel;
  logic [DATA_W-1:0] dbg_val;
  logic [PC_W-1:0]   pc;
  logic              running;
  logic              halted;
  logic [CNT_W-1:0]  retired;

  scpu_pipe #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .dbg_sel    (dbg_sel),
    .dbg_val    (dbg_val),
    .pc         (pc),
    .running    (running),
    .halted     (halted),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [7:0] prog   [DEPTH];
  logic [7:0] mdlMem [DEPTH];
  int         mdlRegs [4];
  int         expRegs [4];
  int         expPc;
  int         expRetired;
  int         expCycles;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // ISA interpreter: executes one instruction per step from PC 0. Timing is
  // one cycle for the first fetch, one per executed instruction and one
  // extra for every taken branch that does not halt.
  task automatic modelRun(input logic [7:0] mem [DEPTH], output bit halts);
    int r [4];
    int p, ret, cyc, op, rd, rs1, rs2, tgt;
    logic [7:0] ins;
    for (int i = 0; i < 4; i++) r[i] = mdlRegs[i];
    p = 0; ret = 0; cyc = 1; halts = 1'b0;
    for (int step = 0; step < 400 && !halts; step++) begin
      ins = mem[p];
      op = ins[7:6]; rd = ins[5:4]; rs1 = ins[3:2]; rs2 = ins[1:0]; tgt = ins[5:2];
      ret++; cyc++;
      case (op)
        0: begin r[rd] = (r[rs1] + r[rs2]) % (1 << DATA_W); p = (p + 1) % DEPTH; end
        1: begin r[rd] = r[rs2]; p = (p + 1) % DEPTH; end
        2: begin r[rd] = ins[3:0]; p = (p + 1) % DEPTH; end
        default: begin
          if (r[rs2] != r[0]) begin
            if (tgt == p) halts = 1'b1;
            else begin p = tgt; cyc++; end
          end else p = (p + 1) % DEPTH;
        end
      endcase
    end
    for (int i = 0; i < 4; i++) expRegs[i] = r[i];
    expPc = p; expRetired = ret; expCycles = cyc;
  endtask

  // Loads prog into memory from the top address down; optionally the final
  // write to address 0 shares its cycle with the start pulse.
  task automatic applyStimulus(input bit startWithWrite);
    for (int a = DEPTH - 1; a >= 0; a--) begin
      @(negedge clk);
      imem_we    = 1'b1;
      imem_addr  = PC_W'(a);
      imem_wdata = prog[a];
      mdlMem[a]  = prog[a];
      start      = startWithWrite && (a == 0);
    end
    @(negedge clk);
    imem_we = 1'b0;
    start   = 1'b0;
    if (!startWithWrite) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic checkRegs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      checkOutput($sformatf("%s/r%0d", tag, i), 32'(dbg_val), 32'(expRegs[i]));
    end
  endtask

  // Waits (bounded) for halt after a start edge and compares with the model.
  task automatic runAndCheck(input string tag, input bit scribble);
    bit h;
    int cyc;
    modelRun(mdlMem, h);
    cyc = 0;
    while (!halted && cyc < BOUND) begin
      if (scribble && cyc < 4) begin
        imem_we    = 1'b1;
        imem_addr  = PC_W'(cyc);
        imem_wdata = 8'h00;
      end else begin
        imem_we = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    imem_we = 1'b0;
    checkOutput({tag, "/halted"}, 32'(halted), 32'(1));
    checkOutput({tag, "/running"}, 32'(running), 32'(0));
    checkOutput({tag, "/cycles"}, 32'(cyc), 32'(expCycles));
    checkOutput({tag, "/pc"}, 32'(pc), 32'(expPc));
    checkOutput({tag, "/retired"}, 32'(retired), 32'(expRetired));
    checkRegs(tag);
    for (int i = 0; i < 4; i++) mdlRegs[i] = expRegs[i];
  endtask

  task automatic checkSumConsts(input string tag);
    int want [4];
    want[0] = 10; want[1] = 10; want[2] = 55; want[3] = 1;
    checkOutput({tag, "/sum_pc"}, 32'(pc), 32'(7));
    checkOutput({tag, "/sum_retired"}, 32'(retired), 32'(35));
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      checkOutput($sformatf("%s/sum_r%0d", tag, i), 32'(dbg_val), 32'(want[i]));
    end
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "/running"}, 32'(running), 32'(0));
    checkOutput({tag, "/halted"}, 32'(halted), 32'(0));
    checkOutput({tag, "/pc"}, 32'(pc), 32'(0));
    checkOutput({tag, "/retired"}, 32'(retired), 32'(0));
    for (int i = 0; i < 4; i++) begin
      expRegs[i] = 0;
      mdlRegs[i] = 0;
    end
    checkRegs(tag);
  endtask

  initial begin
    bit h;
    rst = 1'b1; start = 1'b1; imem_we = 1'b1;
    imem_addr = '0; imem_wdata = 8'h55; dbg_sel = 2'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0; start = 1'b0; imem_we = 1'b0;
    checkIdleZero("reset");

    // Back-to-back dependency.
    prog = '{8'h93, 8'h15, 8'h25, 8'hCD, 8'h00, 8'h00, 8'h00, 8'h00,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(1'b0);
    runAndCheck("dep", 1'b0);
    dbg_sel = 2'd1; #1; checkOutput("dep/r1_const", 32'(dbg_val), 32'(6));
    dbg_sel = 2'd2; #1; checkOutput("dep/r2_const", 32'(dbg_val), 32'(12));

    // Add overflow wraps modulo 2**DATA_W.
    prog = '{8'h80, 8'h9F, 8'h15, 8'h15, 8'h15, 8'h15, 8'hAF, 8'h16,
             8'hB1, 8'h17, 8'hEA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(1'b0);
    runAndCheck("ovf", 1'b0);
    dbg_sel = 2'd1; #1; checkOutput("ovf/r1_const", 32'(dbg_val), 32'(0));

    // PC wrap from 15 to 0, halting at pc 0.
    prog = '{8'hC1, 8'hA1, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
    applyStimulus(1'b0);
    runAndCheck("wrap", 1'b0);
    dbg_sel = 2'd1; #1; checkOutput("wrap/r1_const", 32'(dbg_val), 32'(5));
    checkOutput("wrap/pc_const", 32'(pc), 32'(0));

    // Sum program: write to address 0 shares the start cycle; writes during
    // RUN must be dropped, so an identical rerun follows.
    prog = '{8'h8A, 8'h90, 8'hA0, 8'hB1, 8'h17, 8'h29, 8'hD1, 8'hDF,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(1'b1);
    runAndCheck("sum", 1'b1);
    checkSumConsts("sum");
    pulseStart();
    runAndCheck("rerun", 1'b0);
    checkSumConsts("rerun");

    // Reset mid-loop; a write held under reset (also in IDLE) must be dropped.
    pulseStart();
    repeat (10) @(negedge clk);
    checkOutput("mid/running", 32'(running), 32'(1));
    rst = 1'b1; imem_we = 1'b1; imem_addr = '0; imem_wdata = 8'hFF;
    repeat (2) @(negedge clk);
    rst = 1'b0; imem_we = 1'b0;
    checkIdleZero("midrst");
    pulseStart();
    runAndCheck("postrst", 1'b0);
    checkSumConsts("postrst");

    // Random programs that the interpreter shows to halt.
    for (int n = 0; n < 8; n++) begin
      h = 1'b0;
      for (int t = 0; t < 200 && !h; t++) begin
        for (int a = 0; a < DEPTH; a++) prog[a] = 8'($urandom_range(0, 255));
        modelRun(prog, h);
      end
      if (!h) begin
        prog = '{8'h80, 8'h91, 8'hC9, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      end
      applyStimulus(1'b0);
      runAndCheck($sformatf("rand%0d", n), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
